// File: rtl/ahb_pkg.sv
// Shared AHB-Lite constants, master FSM state type and the local alignment check
// used by ahb_lite_master_arb.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_LERR = 2'd3
  } ahb_state_e;

  // Sizes wider than the bus are always rejected, so only the low three
  // address bits ever matter for the natural-alignment test.
  function automatic logic is_misaligned(input logic [2:0] size,
                                         input logic [2:0] addr_lo,
                                         input logic [2:0] max_size);
    logic bad;
    bad = (size > max_size);
    for (int unsigned i = 0; i < 3; i++) begin
      if ((i < 32'(size)) && addr_lo[i]) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/ahb_req_arbiter.sv
// Requester arbiter: fixed-priority (lowest index) or round-robin, with the
// round-robin pointer advancing past the winner on each accepted grant.
module ahb_req_arbiter #(
  parameter int unsigned NUM_REQ  = 2,
  parameter string       ARB_MODE = "FIXED",
  localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               grant_en,
  output logic [NUM_REQ-1:0] gnt_oh,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_any
);

  localparam bit RR_MODE = (ARB_MODE == "RR");

  logic [IDX_W-1:0] ptr_q, ptr_d;
  int unsigned      cand;

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = RR_MODE ? ((32'(ptr_q) + off) % NUM_REQ) : off;
      if (!gnt_any && req[cand]) begin
        gnt_any      = 1'b1;
        gnt_idx      = IDX_W'(cand);
        gnt_oh[cand] = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_en && gnt_any) begin
      ptr_d = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/ahb_lite_master_arb.sv
// AHB-Lite single-transfer master shared by NUM_REQ internal requesters;
// handles wait states, two-cycle ERROR responses and local misalignment errors.
module ahb_lite_master_arb
  import ahb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter string       ARB_MODE   = "FIXED"
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  input  logic [NUM_REQ*3-1:0]          req_size,
  input  logic [NUM_REQ*4-1:0]          req_prot,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic [ADDR_WIDTH-1:0]         HADDR,
  output logic [2:0]                    HBURST,
  output logic                          HMASTLOCK,
  output logic [3:0]                    HPROT,
  output logic [2:0]                    HSIZE,
  output logic [1:0]                    HTRANS,
  output logic [DATA_WIDTH-1:0]         HWDATA,
  output logic                          HWRITE,
  input  logic [DATA_WIDTH-1:0]         HRDATA,
  input  logic                          HREADY,
  input  logic                          HRESP
);

  localparam int unsigned IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [2:0]  MAX_SIZE = 3'($clog2(DATA_WIDTH / 8));

  ahb_state_e            state_q, state_d;
  logic [IDX_W-1:0]      owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] haddr_q, haddr_d;
  logic                  hwrite_q, hwrite_d;
  logic [2:0]            hsize_q, hsize_d;
  logic [3:0]            hprot_q, hprot_d;
  logic [1:0]            htrans_q, htrans_d;
  logic [DATA_WIDTH-1:0] hwdata_q, hwdata_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  logic [NUM_REQ-1:0]    gnt_oh;
  logic [IDX_W-1:0]      gnt_idx;
  logic                  gnt_any;
  logic                  grant_opp;
  logic                  grant_en;
  logic                  misaligned;
  logic [NUM_REQ-1:0]    owner_oh;

  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  sel_write;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [2:0]            sel_size;
  logic [3:0]            sel_prot;

  // A new request may only be taken from IDLE or in the cycle the current
  // data phase completes, which gives one transfer every two cycles.
  assign grant_opp = (state_q == ST_IDLE) || ((state_q == ST_DATA) && HREADY);
  assign grant_en  = grant_opp && gnt_any;
  assign req_ready = grant_en ? gnt_oh : '0;

  ahb_req_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .clk      (clk),
    .reset    (reset),
    .req      (req_valid),
    .grant_en (grant_opp),
    .gnt_oh   (gnt_oh),
    .gnt_idx  (gnt_idx),
    .gnt_any  (gnt_any)
  );

  always_comb begin
    sel_addr  = '0;
    sel_write = 1'b0;
    sel_wdata = '0;
    sel_size  = '0;
    sel_prot  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_oh[i]) begin
        sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_write = req_write[i];
        sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_size  = req_size[i*3 +: 3];
        sel_prot  = req_prot[i*4 +: 4];
      end
    end
  end

  assign misaligned = is_misaligned(sel_size, sel_addr[2:0], MAX_SIZE);

  always_comb begin
    owner_oh = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      owner_oh[i] = (owner_q == IDX_W'(i));
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    haddr_d     = haddr_q;
    hwrite_d    = hwrite_q;
    hsize_d     = hsize_q;
    hprot_d     = hprot_q;
    htrans_d    = htrans_q;
    hwdata_d    = hwdata_q;
    wdata_d     = wdata_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      ST_ADDR: begin
        if (HREADY) begin
          state_d  = ST_DATA;
          htrans_d = HTRANS_IDLE;
          hwdata_d = wdata_q;
        end
      end
      ST_DATA: begin
        if (HREADY) begin
          state_d     = ST_IDLE;
          rsp_valid_d = owner_oh;
          rsp_rdata_d = hwrite_q ? '0 : HRDATA;
          rsp_err_d   = HRESP;
        end
      end
      ST_LERR: begin
        state_d     = ST_IDLE;
        rsp_valid_d = owner_oh;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b1;
      end
      default: ;
    endcase

    // Grant overrides the DATA->IDLE move; the response above still uses the
    // outgoing owner and write flag because it reads the _q copies.
    if (grant_en) begin
      owner_d = gnt_idx;
      if (misaligned) begin
        state_d = ST_LERR;
      end else begin
        state_d  = ST_ADDR;
        htrans_d = HTRANS_NONSEQ;
        haddr_d  = sel_addr;
        hwrite_d = sel_write;
        hsize_d  = sel_size;
        hprot_d  = sel_prot;
        wdata_d  = sel_wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      hsize_q     <= '0;
      hprot_q     <= '0;
      htrans_q    <= HTRANS_IDLE;
      hwdata_q    <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      haddr_q     <= haddr_d;
      hwrite_q    <= hwrite_d;
      hsize_q     <= hsize_d;
      hprot_q     <= hprot_d;
      htrans_q    <= htrans_d;
      hwdata_q    <= hwdata_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign HADDR     = haddr_q;
  assign HBURST    = HBURST_SINGLE;
  assign HMASTLOCK = 1'b0;
  assign HPROT     = hprot_q;
  assign HSIZE     = hsize_q;
  assign HTRANS    = htrans_q;
  assign HWDATA    = hwdata_q;
  assign HWRITE    = hwrite_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
